// File: rtl/io_predication_multi_if.sv
// Bus bundle for the I/O predication block: stage-0 operand addresses,
// per-port empty/full flags, predication results and timeout control.
interface io_predication_multi_if #(
    parameter int MEM_COUNT    = 2,
    parameter int ADDR_WIDTH   = 10,
    parameter int PORT_COUNT   = 8,
    parameter int THREAD_COUNT = 8,
    parameter int THREAD_WIDTH = 3
);
    logic [THREAD_WIDTH-1:0]          thread_id;
    logic [MEM_COUNT-1:0]             read_enable;
    logic [MEM_COUNT*ADDR_WIDTH-1:0]  read_addr;
    logic [MEM_COUNT-1:0]             write_enable;
    logic [MEM_COUNT*ADDR_WIDTH-1:0]  write_addr;
    logic [MEM_COUNT*PORT_COUNT-1:0]  read_EF;
    logic [MEM_COUNT*PORT_COUNT-1:0]  write_EF;
    logic [MEM_COUNT*PORT_COUNT-1:0]  io_rden;
    logic [MEM_COUNT*PORT_COUNT-1:0]  io_wren;
    logic [MEM_COUNT-1:0]             read_addr_is_IO;
    logic [MEM_COUNT-1:0]             write_addr_is_IO;
    logic                             IO_ready;
    logic [THREAD_COUNT-1:0]          timeout;
    logic [THREAD_COUNT-1:0]          timeout_clear;

    // Instruction-issue side: drives addresses, flags and timeout clears.
    modport master (
        output thread_id, read_enable, read_addr, write_enable, write_addr,
               read_EF, write_EF, timeout_clear,
        input  io_rden, io_wren, read_addr_is_IO, write_addr_is_IO,
               IO_ready, timeout
    );

    // Predication block side.
    modport slave (
        input  thread_id, read_enable, read_addr, write_enable, write_addr,
               read_EF, write_EF, timeout_clear,
        output io_rden, io_wren, read_addr_is_IO, write_addr_is_IO,
               IO_ready, timeout
    );
endinterface

// File: rtl/io_predication_multi.sv
// Multi-memory I/O predication: decodes each memory's read/write address
// against the I/O window, registers the decode one stage, then masks the
// port empty/full flags into a single IO_ready (annul) and gated strobes.
// Per-thread consecutive-annul counters raise a sticky timeout flag.
module io_predication_multi #(
    parameter int MEM_COUNT      = 2,
    parameter int ADDR_WIDTH     = 10,
    parameter int PORT_COUNT     = 8,
    parameter int PORT_BASE_ADDR = 1016,
    parameter int THREAD_COUNT   = 8,
    parameter int THREAD_WIDTH   = 3,
    parameter int TIMEOUT_LIMIT  = 16,
    parameter int COUNT_WIDTH    = 5
) (
    input  logic                  clock,
    input  logic                  clear,
    io_predication_multi_if.slave bus
);
    localparam int IDX_WIDTH = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        int a;
        a = 32'(addr);
        return (a >= PORT_BASE_ADDR) && (a < PORT_BASE_ADDR + PORT_COUNT);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] port_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] diff;
        diff = addr - ADDR_WIDTH'(PORT_BASE_ADDR);
        return diff[IDX_WIDTH-1:0];
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    // Compared unsaturated so a counter already pinned at max never re-fires.
    function automatic logic hits_limit(input logic [COUNT_WIDTH-1:0] cnt);
        return ({1'b0, cnt} + 1'b1) == (COUNT_WIDTH+1)'(TIMEOUT_LIMIT);
    endfunction

    logic [MEM_COUNT-1:0]    rd_io_p0, wr_io_p0;
    logic [IDX_WIDTH-1:0]    rd_idx_p0 [MEM_COUNT];
    logic [IDX_WIDTH-1:0]    wr_idx_p0 [MEM_COUNT];

    logic [MEM_COUNT-1:0]    rd_io_p1, wr_io_p1;
    logic [IDX_WIDTH-1:0]    rd_idx_p1 [MEM_COUNT];
    logic [IDX_WIDTH-1:0]    wr_idx_p1 [MEM_COUNT];
    logic [THREAD_WIDTH-1:0] thread_p1;

    logic                            ready_p1;
    logic [MEM_COUNT*PORT_COUNT-1:0] rden_p1, wren_p1;

    logic [COUNT_WIDTH-1:0]  annul_count [THREAD_COUNT];
    logic [THREAD_COUNT-1:0] timeout_flag;

    // Stage 0: window decode and port index per memory and direction.
    always_comb begin
        for (int m = 0; m < MEM_COUNT; m++) begin
            rd_io_p0[m]  = bus.read_enable[m]  && in_window(bus.read_addr[m*ADDR_WIDTH +: ADDR_WIDTH]);
            wr_io_p0[m]  = bus.write_enable[m] && in_window(bus.write_addr[m*ADDR_WIDTH +: ADDR_WIDTH]);
            rd_idx_p0[m] = port_index(bus.read_addr[m*ADDR_WIDTH +: ADDR_WIDTH]);
            wr_idx_p0[m] = port_index(bus.write_addr[m*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    // Stage 0 -> 1 register; clear flushes the slot so nothing is predicated.
    always_ff @(posedge clock) begin
        if (clear) begin
            rd_io_p1  <= '0;
            wr_io_p1  <= '0;
            thread_p1 <= '0;
            for (int m = 0; m < MEM_COUNT; m++) begin
                rd_idx_p1[m] <= '0;
                wr_idx_p1[m] <= '0;
            end
        end else begin
            rd_io_p1  <= rd_io_p0;
            wr_io_p1  <= wr_io_p0;
            thread_p1 <= bus.thread_id;
            for (int m = 0; m < MEM_COUNT; m++) begin
                rd_idx_p1[m] <= rd_idx_p0[m];
                wr_idx_p1[m] <= wr_idx_p0[m];
            end
        end
    end

    // Stage 1: mask EF flags into IO_ready, then gate one-hot strobes by it.
    always_comb begin
        ready_p1 = 1'b1;
        rden_p1  = '0;
        wren_p1  = '0;
        for (int m = 0; m < MEM_COUNT; m++) begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                if (rd_io_p1[m] && rd_idx_p1[m] == IDX_WIDTH'(p) && !bus.read_EF[m*PORT_COUNT+p])
                    ready_p1 = 1'b0;
                if (wr_io_p1[m] && wr_idx_p1[m] == IDX_WIDTH'(p) && !bus.write_EF[m*PORT_COUNT+p])
                    ready_p1 = 1'b0;
            end
        end
        for (int m = 0; m < MEM_COUNT; m++) begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                rden_p1[m*PORT_COUNT+p] = ready_p1 && rd_io_p1[m] && rd_idx_p1[m] == IDX_WIDTH'(p);
                wren_p1[m*PORT_COUNT+p] = ready_p1 && wr_io_p1[m] && wr_idx_p1[m] == IDX_WIDTH'(p);
            end
        end
    end

    // End of stage 1: per-thread annul counting; timeout_clear overrides the update.
    always_ff @(posedge clock) begin
        if (clear) begin
            timeout_flag <= '0;
            for (int t = 0; t < THREAD_COUNT; t++) annul_count[t] <= '0;
        end else begin
            for (int t = 0; t < THREAD_COUNT; t++) begin
                if (bus.timeout_clear[t]) begin
                    annul_count[t]  <= '0;
                    timeout_flag[t] <= 1'b0;
                end else if (thread_p1 == THREAD_WIDTH'(t)) begin
                    if (ready_p1) begin
                        annul_count[t] <= '0;
                    end else begin
                        annul_count[t] <= sat_inc(annul_count[t]);
                        if (hits_limit(annul_count[t])) timeout_flag[t] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.read_addr_is_IO  = rd_io_p1;
    assign bus.write_addr_is_IO = wr_io_p1;
    assign bus.IO_ready         = ready_p1;
    assign bus.io_rden          = rden_p1;
    assign bus.io_wren          = wren_p1;
    assign bus.timeout          = timeout_flag;
endmodule
